pong_ctrl_2p: RTL and testbench

PONG_CTRL_2P -- requirements
Module: pong_ctrl_2p

---
 rtl/pong_ctrl_2p.sv | 238 +++++++++++++++++++++++
 tb/tb_pong_ctrl_2p.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pong_ctrl_2p.sv
// Control FSM for a one/two-player LED-bar pong game. Synchronizes the button and
// ball-step inputs, moves a one-hot ball and drives the score/timer counter controls.
module pong_ctrl_2p #(
    parameter int LED_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_p1_btn,
    input  logic             i_p2_btn,
    input  logic             i_clk_out,
    input  logic             i_t5_out,
    input  logic             i_winner,
    output logic             o_t5_en,
    output logic             o_t5_rst,
    output logic             o_t20_en,
    output logic             o_t20_rst,
    output logic             o_hit_ld,
    output logic             o_hit_clr,
    output logic             o_lvl_clr,
    output logic             o_p1_ld,
    output logic             o_p1_clr,
    output logic             o_p2_ld,
    output logic             o_p2_clr,
    output logic [LED_W-1:0] o_led,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [LED_W-1:0] LED_P2  = LED_W'(1);
    localparam logic [LED_W-1:0] LED_P1  = LED_P2 << (LED_W - 1);
    localparam logic [LED_W-1:0] LED_ALL = {LED_W{1'b1}};

    state_t            r_state, w_state_nx;
    logic [LED_W-1:0]  r_led, w_led_nx;
    logic              r_dir, w_dir_nx;          // 1 = toward P1 end (MSB)
    logic              r_serve_p2, w_serve_p2_nx;
    logic              r_game_mode, w_game_mode_nx;
    logic              r_hit_ld, w_hit_ld_nx;
    logic              r_p1_ld, w_p1_ld_nx;
    logic              r_p2_ld, w_p2_ld_nx;
    logic              r_post, w_post_nx;        // cycle after a score strobe drops
    logic              r_t5_rst, w_t5_rst_nx;

    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]        w_sync_s;
    logic              r_start_d, r_clkout_d, r_start_ev, r_step;
    logic              w_start_s, w_mode_s, w_p1_s, w_p2_s, w_clkout_s;

    assign w_sync_s = r_sync[SYNC_STAGES-1];
    assign {w_start_s, w_mode_s, w_p1_s, w_p2_s, w_clkout_s} = w_sync_s;

    // Input synchronizers plus registered edge detectors for Start and Clk_out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync     <= '0;
            r_start_d  <= 1'b0;
            r_clkout_d <= 1'b0;
            r_start_ev <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_sync[0] <= {i_start, i_mode, i_p1_btn, i_p2_btn, i_clk_out};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_start_d  <= w_start_s;
            r_clkout_d <= w_clkout_s;
            r_start_ev <= w_start_s & ~r_start_d;
            r_step     <= w_clkout_s & ~r_clkout_d;
        end
    end

    // Game state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_led       <= '0;
            r_dir       <= 1'b0;
            r_serve_p2  <= 1'b0;
            r_game_mode <= 1'b0;
            r_hit_ld    <= 1'b0;
            r_p1_ld     <= 1'b0;
            r_p2_ld     <= 1'b0;
            r_post      <= 1'b0;
            r_t5_rst    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_led       <= w_led_nx;
            r_dir       <= w_dir_nx;
            r_serve_p2  <= w_serve_p2_nx;
            r_game_mode <= w_game_mode_nx;
            r_hit_ld    <= w_hit_ld_nx;
            r_p1_ld     <= w_p1_ld_nx;
            r_p2_ld     <= w_p2_ld_nx;
            r_post      <= w_post_nx;
            r_t5_rst    <= w_t5_rst_nx;
        end
    end

    // Next-state logic: serve, ball motion, returns, misses and strobes
    always_comb begin
        w_state_nx     = r_state;
        w_led_nx       = r_led;
        w_dir_nx       = r_dir;
        w_serve_p2_nx  = r_serve_p2;
        w_game_mode_nx = r_game_mode;
        w_hit_ld_nx    = r_hit_ld;
        w_p1_ld_nx     = r_p1_ld;
        w_p2_ld_nx     = r_p2_ld;
        w_post_nx      = r_post;
        w_t5_rst_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                w_led_nx    = '0;
                w_hit_ld_nx = 1'b0;
                w_p1_ld_nx  = 1'b0;
                w_p2_ld_nx  = 1'b0;
                w_post_nx   = 1'b0;
                if (r_start_ev) begin
                    w_game_mode_nx = w_mode_s;
                    w_serve_p2_nx  = 1'b0;
                    w_state_nx     = SERVE;
                    w_t5_rst_nx    = 1'b1;
                    w_led_nx       = LED_P1;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            SERVE: begin
                w_led_nx = r_serve_p2 ? LED_P2 : LED_P1;
                if (r_start_ev) begin
                    w_state_nx = IDLE;
                    w_led_nx   = '0;
                end else if (i_t5_out && !r_t5_rst) begin
                    w_state_nx = PLAY;
                    w_dir_nx   = r_serve_p2;
                end else begin
                    w_state_nx = SERVE;
                end
            end
            PLAY: begin
                if (r_start_ev) begin
                    w_state_nx  = IDLE;
                    w_led_nx    = '0;
                    w_hit_ld_nx = 1'b0;
                    w_p1_ld_nx  = 1'b0;
                    w_p2_ld_nx  = 1'b0;
                    w_post_nx   = 1'b0;
                end else if (r_post) begin
                    w_post_nx = 1'b0;
                    if (i_winner) begin
                        w_state_nx = OVER;
                        w_led_nx   = LED_ALL;
                    end else begin
                        w_state_nx  = SERVE;
                        w_t5_rst_nx = 1'b1;
                        w_led_nx    = r_serve_p2 ? LED_P2 : LED_P1;
                    end
                end else if (!r_step) begin
                    w_state_nx = PLAY;
                end else if (r_p1_ld || r_p2_ld) begin
                    w_p1_ld_nx = 1'b0;
                    w_p2_ld_nx = 1'b0;
                    w_post_nx  = 1'b1;
                end else begin
                    w_hit_ld_nx = 1'b0;
                    if (r_led[0] && !r_dir) begin
                        if (!r_game_mode || w_p2_s) begin
                            w_dir_nx = 1'b1;
                            w_led_nx = LED_P2 << 1;
                        end else begin
                            w_p1_ld_nx    = 1'b1;
                            w_led_nx      = '0;
                            w_serve_p2_nx = 1'b1;
                        end
                    end else if (r_led[LED_W-1] && r_dir) begin
                        if (w_p1_s) begin
                            w_dir_nx    = 1'b0;
                            w_led_nx    = LED_P1 >> 1;
                            w_hit_ld_nx = !r_game_mode;
                        end else if (r_game_mode) begin
                            w_p2_ld_nx    = 1'b1;
                            w_led_nx      = '0;
                            w_serve_p2_nx = 1'b0;
                        end else begin
                            w_state_nx = OVER;
                            w_led_nx   = LED_ALL;
                        end
                    end else if (r_dir) begin
                        w_led_nx = r_led << 1;
                    end else begin
                        w_led_nx = r_led >> 1;
                    end
                end
            end
            OVER: begin
                w_led_nx    = LED_ALL;
                w_hit_ld_nx = 1'b0;
                w_p1_ld_nx  = 1'b0;
                w_p2_ld_nx  = 1'b0;
                w_post_nx   = 1'b0;
                if (r_start_ev) begin
                    w_state_nx = IDLE;
                    w_led_nx   = '0;
                end else begin
                    w_state_nx = OVER;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_led_nx   = '0;
            end
        endcase
    end

    assign o_state   = r_state;
    assign o_led     = r_led;
    assign o_hit_ld  = r_hit_ld;
    assign o_p1_ld   = r_p1_ld;
    assign o_p2_ld   = r_p2_ld;
    assign o_t5_rst  = r_t5_rst;
    assign o_t5_en   = (r_state == SERVE) && !r_t5_rst;
    assign o_t20_en  = (r_state == PLAY) && !r_game_mode;
    assign o_t20_rst = (r_state == IDLE);
    assign o_hit_clr = (r_state == IDLE);
    assign o_lvl_clr = (r_state == IDLE);
    assign o_p1_clr  = (r_state == IDLE);
    assign o_p2_clr  = (r_state == IDLE);

endmodule

// File: tb/tb_pong_ctrl_2p.sv
// Directed bench for pong_ctrl_2p: two-player scoring/over, one-player returns,
// wall bounce, held-button immunity and reset during a Hit_ld strobe.
module tb_pong_ctrl_2p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, p1_btn = 1'b0, p2_btn = 1'b0;
    logic        clk_out = 1'b0, t5_out = 1'b0, winner = 1'b0;
    logic        t5_en, t5_rst, t20_en, t20_rst;
    logic        hit_ld, hit_clr, lvl_clr, p1_ld, p1_clr, p2_ld, p2_clr;
    logic [15:0] led;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    pong_ctrl_2p #(.LED_W(16), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .i_p1_btn(p1_btn), .i_p2_btn(p2_btn), .i_clk_out(clk_out),
        .i_t5_out(t5_out), .i_winner(winner),
        .o_t5_en(t5_en), .o_t5_rst(t5_rst), .o_t20_en(t20_en), .o_t20_rst(t20_rst),
        .o_hit_ld(hit_ld), .o_hit_clr(hit_clr), .o_lvl_clr(lvl_clr),
        .o_p1_ld(p1_ld), .o_p1_clr(p1_clr), .o_p2_ld(p2_ld), .o_p2_clr(p2_clr),
        .o_led(led), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_ball(input int n);
        repeat (n) begin
            clk_out = 1'b1;
            cycles(6);
            clk_out = 1'b0;
            cycles(6);
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        cycles(6);
        start = 1'b0;
        cycles(6);
    endtask

    task automatic serve_timeout();
        cycles(3);
        t5_out = 1'b1;
        cycles(3);
        t5_out = 1'b0;
        cycles(2);
    endtask

    initial begin
        cycles(3);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_ld_en", 32'({hit_ld, p1_ld, p2_ld, t5_en, t20_en, t5_rst}), 32'h0);
        chk("rst_clr", 32'({hit_clr, lvl_clr, p1_clr, p2_clr, t20_rst}), 32'h1F);
        rst = 1'b0;
        cycles(3);

        // Two-player game
        mode = 1'b1;
        press_start();
        chk("2p_serve_state", 32'(state), 32'h1);
        chk("2p_serve_led", 32'(led), 32'h8000);
        chk("2p_t5_en", 32'(t5_en), 32'h1);
        serve_timeout();
        chk("2p_play_state", 32'(state), 32'h2);
        step_ball(1);
        chk("2p_first_step", 32'(led), 32'h4000);
        step_ball(14);
        chk("2p_at_bit0", 32'(led), 32'h0001);
        step_ball(1);
        chk("2p_p1_ld_on", 32'({p1_ld, p2_ld}), 32'h2);
        chk("2p_miss_led", 32'(led), 32'h0);
        step_ball(1);
        chk("2p_p1_ld_off", 32'(p1_ld), 32'h0);
        chk("2p_reserve_state", 32'(state), 32'h1);
        chk("2p_reserve_led", 32'(led), 32'h0001);
        serve_timeout();
        step_ball(1);
        chk("2p_p2_serve_dir", 32'(led), 32'h0002);
        step_ball(14);
        chk("2p_at_bit15", 32'(led), 32'h8000);
        p1_btn = 1'b1;
        step_ball(1);
        p1_btn = 1'b0;
        chk("2p_p1_return", 32'(led), 32'h4000);
        chk("2p_no_hit_ld", 32'(hit_ld), 32'h0);
        step_ball(14);
        p2_btn = 1'b1;
        step_ball(1);
        p2_btn = 1'b0;
        chk("2p_p2_return", 32'(led), 32'h0002);
        step_ball(14);
        winner = 1'b1;
        step_ball(1);
        chk("2p_p2_ld_on", 32'({p1_ld, p2_ld}), 32'h1);
        step_ball(1);
        chk("2p_over_state", 32'(state), 32'h3);
        chk("2p_over_led", 32'(led), 32'hFFFF);
        chk("2p_over_ld", 32'({hit_ld, p1_ld, p2_ld, t5_en, t20_en}), 32'h0);
        winner = 1'b0;
        press_start();
        chk("2p_idle", 32'(state), 32'h0);
        chk("2p_idle_led", 32'(led), 32'h0);

        // One-player game; mode change after start must be ignored
        mode = 1'b0;
        press_start();
        mode = 1'b1;
        serve_timeout();
        chk("1p_t20_en", 32'({t20_en, t20_rst}), 32'h2);
        p1_btn = 1'b1;
        step_ball(15);
        chk("1p_held_btn_led", 32'(led), 32'h0001);
        chk("1p_held_btn_hit", 32'(hit_ld), 32'h0);
        step_ball(1);
        chk("1p_wall_bounce", 32'(led), 32'h0002);
        step_ball(14);
        step_ball(1);
        chk("1p_return_led", 32'(led), 32'h4000);
        chk("1p_hit_on", 32'(hit_ld), 32'h1);
        step_ball(1);
        chk("1p_hit_off", 32'(hit_ld), 32'h0);
        chk("1p_led_2000", 32'(led), 32'h2000);
        p1_btn = 1'b0;
        step_ball(13);
        step_ball(1);
        step_ball(14);
        chk("1p_at_bit15", 32'(led), 32'h8000);
        step_ball(1);
        chk("1p_over_state", 32'(state), 32'h3);
        chk("1p_over_led", 32'(led), 32'hFFFF);
        chk("1p_over_t20", 32'(t20_en), 32'h0);
        press_start();
        chk("1p_idle", 32'(state), 32'h0);

        // Reset while Hit_ld is high
        mode = 1'b0;
        press_start();
        serve_timeout();
        p1_btn = 1'b1;
        step_ball(16);
        step_ball(14);
        step_ball(1);
        chk("rst_pre_hit", 32'(hit_ld), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_state", 32'(state), 32'h0);
        chk("rst_mid_outs", 32'({hit_ld, p1_ld, p2_ld, t5_en, t20_en, t5_rst}), 32'h0);
        chk("rst_mid_led", 32'(led), 32'h0);
        chk("rst_mid_clr", 32'({hit_clr, lvl_clr, p1_clr, p2_clr, t20_rst}), 32'h1F);
        cycles(2);
        rst = 1'b0;
        step_ball(2);
        chk("rst_no_hit_after", 32'({hit_ld, state}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
